fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry payload, NOP filler, count width helper.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned fq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  fq_entry_t                     push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [fq_cnt_w(DEPTH)-1:0]    count,
  output fq_entry_t                     head
);

  localparam int unsigned CNT_W = fq_cnt_w(DEPTH);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fq_entry_t          mem_q [DEPTH];
  fq_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {32'h0000_0000, NOP_INST};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // Upstream credit accounting must never let a push land in a full queue.
  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC/credit/kill control in front of a 1-cycle icache, feeding decode via fetch_queue.
// Optional perf counters enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_en,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CNT_W = fq_cnt_w(FQ_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic             kill_q, kill_d;
  logic             issue;
  logic             fq_push;
  logic             fq_pop;
  logic [CNT_W-1:0] fq_count;
  fq_entry_t        fq_head;
  fq_entry_t        fq_wdata;

  // Credits cover both queued entries and the response still in the icache pipe.
  assign issue = rst_n && !redirect_valid &&
                 (({1'b0, fq_count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(FQ_DEPTH));

  assign fq_push  = ic_rvalid && inflight_q && !kill_q && !redirect_valid;
  assign fq_pop   = out_valid && out_ready;
  assign fq_wdata = '{pc: req_pc_q, inst: ic_rdata};

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~32'h0000_0003;
      kill_d = inflight_q;
    end else if (issue) begin
      pc_d       = pc_q + 32'd4;
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fq_push),
    .push_data (fq_wdata),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .count     (fq_count),
    .head      (fq_head)
  );

  assign ic_en     = issue;
  assign ic_addr   = pc_q;
  assign out_valid = (fq_count != '0);
  assign out_pc    = fq_head.pc;
  assign out_inst  = fq_head.inst;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_killed_q, perf_killed_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(fq_push);
    perf_killed_d  = perf_killed_q + 32'(ic_rvalid && inflight_q && (kill_q || redirect_valid));
    perf_stall_d   = perf_stall_q + 32'(!issue && !redirect_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_killed_q  <= perf_killed_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table per cycle plus hand sequences for backpressure and perf.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_killed;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ic_en          (ic_en),
    .ic_addr        (ic_addr),
    .ic_rdata       (ic_rdata),
    .ic_rvalid      (ic_rvalid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Icache model: data for the requested word one cycle after ic_en.
  always @(posedge clk) begin
    ic_rvalid <= ic_en;
    ic_rdata  <= inst_of(ic_addr);
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        chk;
    logic        en;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_rst();
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0});
  endtask

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic en, input logic [31:0] addr, input logic vld, input logic [31:0] pc);
    vecs.push_back('{1'b0, rdy, redir, rpc, 1'b1, en, addr, vld, pc});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic step(input logic rst, input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    rst_n          = !rst;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    int hs;
    int got;
    logic seen_issue;

    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Scenario 1: streaming from reset
    add_rst();
    add(1, 0, 0, 1, 32'h0,  0, 0);
    add(1, 0, 0, 1, 32'h4,  0, 0);
    add(1, 0, 0, 1, 32'h8,  1, 32'h0);
    add(1, 0, 0, 1, 32'hC,  1, 32'h4);
    add(1, 0, 0, 1, 32'h10, 1, 32'h8);
    add(1, 0, 0, 1, 32'h14, 1, 32'hC);
    // Scenario 4: redirect coincident with rvalid and a pop
    add_rst();
    add(1, 0, 0, 1, 32'h0,  0, 0);
    add(1, 0, 0, 1, 32'h4,  0, 0);
    add(1, 0, 0, 1, 32'h8,  1, 32'h0);
    add(1, 1, 32'h200, 0, 32'hC, 1, 32'h4);
    add(1, 0, 0, 1, 32'h200, 0, 0);
    add(1, 0, 0, 1, 32'h204, 0, 0);
    add(1, 0, 0, 1, 32'h208, 1, 32'h200);
    add(1, 0, 0, 1, 32'h20C, 1, 32'h204);
    // Scenario 5: wrap at the top of the address space
    add_rst();
    add(1, 1, 32'hFFFF_FFF8, 0, 32'h0, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    add(1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFF8);
    add(1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC);
    add(1, 0, 0, 1, 32'h8, 1, 32'h0);
    // Scenario 3: redirect to unaligned target while PC 0 is in flight
    add_rst();
    add(1, 0, 0, 1, 32'h0, 0, 0);
    add(1, 1, 32'h103, 0, 32'h4, 0, 0);
    add(1, 0, 0, 1, 32'h100, 0, 0);
    add(1, 0, 0, 1, 32'h104, 0, 0);
    add(1, 0, 0, 1, 32'h108, 1, 32'h100);
    add(1, 0, 0, 1, 32'h10C, 1, 32'h104);

    hs = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      if (vecs[i].rst) hs = 0;
      if (vecs[i].chk) begin
        check($sformatf("row%0d ic_en", i), 32'(ic_en), 32'(vecs[i].en));
        check($sformatf("row%0d ic_addr", i), ic_addr, vecs[i].addr);
        check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].vld));
        if (vecs[i].rst) begin
          check($sformatf("row%0d reset out_pc", i), out_pc, 32'h0);
          check($sformatf("row%0d reset out_inst", i), out_inst, 32'h0000_0013);
        end else if (vecs[i].vld) begin
          check($sformatf("row%0d out_pc", i), out_pc, vecs[i].pc);
          check($sformatf("row%0d out_inst", i), out_inst, inst_of(vecs[i].pc));
        end
      end
      if (!vecs[i].rst && vecs[i].rdy && vecs[i].vld && !vecs[i].redir) hs++;
    end

    // Continue scenario 3: stall decode so the queue fills to a known depth.
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("s3 full out_valid", 32'(out_valid), 32'h1);
    check("s3 full ic_en", 32'(ic_en), 32'h0);
    check("s3 full out_pc", out_pc, 32'h108);
`ifdef FETCH_PERF_CNT_EN
    check("perf_killed", perf_killed, 32'd1);
    check("perf_fetched", perf_fetched, 32'(hs + 4));
`endif

    // Scenario 2: backpressure from reset, then drain in order.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, 32'h0);
    check("s2 stalled out_valid", 32'(out_valid), 32'h1);
    check("s2 stalled ic_en", 32'(ic_en), 32'h0);
    check("s2 stalled ic_addr", ic_addr, 32'h10);
    check("s2 stalled out_pc", out_pc, 32'h0);
    got = 0;
    seen_issue = 1'b0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (ic_en && !seen_issue) begin
        seen_issue = 1'b1;
        check("s2 resume ic_addr", ic_addr, 32'h10);
      end
      if (out_valid) begin
        check($sformatf("s2 drain%0d out_pc", got), out_pc, 32'(4 * got));
        got++;
      end
    end
    check("s2 drained count", 32'(got), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
